// File: rtl/vmsu_pkg.sv
// vmsu_pkg: shared types and defaults for the multiplier sequencer and its result FIFO.
package vmsu_pkg;
    localparam int OP_W        = 8;
    localparam int PROD_W      = 16;
    localparam int MUL_LAT_DEF = 2;
    localparam int DEPTH_DEF   = 4;
    typedef enum logic [1:0] {IDLE, WAIT, CAPT} state_e;
endpackage

// File: rtl/vmsu_rsp_fifo.sv
// vmsu_rsp_fifo: power-of-two result FIFO with occupancy count; pops on an empty FIFO are ignored.
module vmsu_rsp_fifo
    import vmsu_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [PROD_W-1:0] data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [PROD_W-1:0] data_o,
    output logic [3:0]        fill_o
);
    localparam int AW = $clog2(DEPTH);
    logic [PROD_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_q, wr_q;
    logic [3:0]        cnt_q;
    logic              pop;
    assign valid_o = cnt_q != 4'd0;
    assign pop     = pop_i && valid_o;
    assign fill_o  = cnt_q;
    assign data_o  = valid_o ? mem_q[rd_q] : '0;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + 4'(push_i) - 4'(pop);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/vmsu_seq.sv
// vmsu_seq: one-job-in-flight sequencer driving an external fixed-latency multiplier,
// capturing each product into a result FIFO.
module vmsu_seq
    import vmsu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_a,
    input  logic [OP_W-1:0]   req_b,
    input  logic              req_ctrl,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    output logic              mul_control,
    input  logic [PROD_W-1:0] mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [PROD_W-1:0] rsp_data,
    output logic              busy,
    output logic [3:0]        fill,
    output logic [7:0]        jobs_done
);
    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [OP_W-1:0] a_q, a_d, b_q, b_d;
    logic            ctrl_q, ctrl_d;
    logic [7:0]      jobs_q, jobs_d;
    logic            push;
    // fill only falls while a job is in flight, so this check alone prevents overflow
    assign req_ready   = (state_q == IDLE) && (fill < 4'(DEPTH));
    assign busy        = state_q != IDLE;
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign mul_control = ctrl_q;
    assign jobs_done   = jobs_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        jobs_d  = jobs_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (req_valid && req_ready) begin
                a_d     = req_a;
                b_d     = req_b;
                ctrl_d  = req_ctrl;
                cnt_d   = 4'(MUL_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                state_d = (cnt_q == 4'd0) ? CAPT : WAIT;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            CAPT: begin
                push    = 1'b1;
                jobs_d  = jobs_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= 1'b0;
            jobs_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            jobs_q  <= jobs_d;
        end
    end
    vmsu_rsp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push),
        .data_i  (mul_p),
        .pop_i   (rsp_ready),
        .valid_o (rsp_valid),
        .data_o  (rsp_data),
        .fill_o  (fill)
    );
endmodule

// File: tb/tb_vmsu_seq.sv
// tb_vmsu_seq: directed scoreboard bench for vmsu_seq with a pipelined multiplier model.
module tb_vmsu_seq;
    localparam int ML = 2;
    localparam int DP = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid, req_ready, req_ctrl, mul_control, rsp_valid, rsp_ready, busy;
    logic [7:0]  req_a, req_b, mul_a, mul_b, jobs_done;
    logic [15:0] mul_p, rsp_data;
    logic [3:0]  fill;
    int          n_chk = 0, n_fail = 0, acc_cnt = 0, start;
    logic [15:0] exp_q[$];
    logic [15:0] pipe [ML];
    logic [16:0] prev_m;
    logic        prev_busy = 1'b0;

    always #5 clk = ~clk;

    vmsu_seq #(.MUL_LAT(ML), .DEPTH(DP)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .mul_a(mul_a), .mul_b(mul_b),
        .mul_control(mul_control), .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .fill(fill), .jobs_done(jobs_done)
    );

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic c);
        return c ? 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b})) : 16'({8'h0, a} * {8'h0, b});
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Multiplier whose output reflects operands only after ML clock edges
    always @(posedge clk) begin
        pipe[0] <= model(mul_a, mul_b, mul_control);
        for (int i = 1; i < ML; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_p = pipe[ML-1];

    always @(negedge clk) begin
        if (!rst && req_valid && req_ready) acc_cnt++;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_unexpected: got 0x%0h expected no response", rsp_data);
            end else check("rsp_data", {16'h0, rsp_data}, {16'h0, exp_q.pop_front()});
        end
        if (!rst && busy && prev_busy) check("mul_stable", {15'h0, mul_a, mul_b, mul_control}, {15'h0, prev_m});
        prev_m    = {mul_a, mul_b, mul_control};
        prev_busy = busy && !rst;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c, input logic [15:0] e);
        int t = 0;
        req_a = a; req_b = b; req_ctrl = c; req_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready && t < 200);
        check("send_accept", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mul_a"}, mul_a, 0);
        check({tag, "_mul_b"}, mul_b, 0);
        check({tag, "_mul_ctrl"}, mul_control, 0);
        check({tag, "_jobs"}, jobs_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_fill"}, fill, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    initial begin
        req_valid = 0; req_a = 0; req_b = 0; req_ctrl = 0; rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rst = 0;
        // first job: latency and data
        send(8'd3, 8'd5, 1'b0, 16'h000F);
        repeat (ML) begin
            @(posedge clk);
            #1 check("rsp_valid_early", rsp_valid, 0);
        end
        @(posedge clk);
        #1 check("rsp_valid_rise", rsp_valid, 1);
        check("rsp_data_first", rsp_data, 16'h000F);
        check("jobs_first", jobs_done, 1);
        drain();
        // unsigned vs signed mode
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        send(8'hFF, 8'hFF, 1'b1, 16'h0001);
        drain();
        check("jobs_three", jobs_done, 3);
        // back-pressure: four accepted, further offers stall
        rsp_ready = 0;
        start = acc_cnt;
        send(8'd1, 8'd2, 1'b0, 16'd2);
        send(8'd2, 8'd3, 1'b0, 16'd6);
        send(8'd3, 8'd4, 1'b0, 16'd12);
        send(8'd4, 8'd5, 1'b0, 16'd20);
        req_a = 8'd9; req_b = 8'd9; req_ctrl = 0; req_valid = 1;
        repeat (12) @(posedge clk);
        req_a = 8'd10; req_b = 8'd10;
        repeat (12) @(posedge clk);
        #1 check("accepted_four", acc_cnt - start, 4);
        check("fill_full", fill, 4);
        check("req_ready_full", req_ready, 0);
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        check("fill_after_pop", fill, 3);
        check("req_ready_after_pop", req_ready, 1);
        send(8'd10, 8'd10, 1'b0, 16'd100);
        repeat (ML + 1) @(posedge clk);
        #1 check("accepted_five", acc_cnt - start, 5);
        check("fill_refull", fill, 4);
        check("req_ready_refull", req_ready, 0);
        // simultaneous push and pop at the highest reachable fill
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        send(8'h12, 8'h34, 1'b0, 16'h03A8);
        repeat (ML) @(posedge clk);
        #1 check("busy_capt", busy, 1);
        rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        check("fill_pushpop_hi", fill, 3);
        check("busy_after_capt", busy, 0);
        rsp_ready = 1;
        drain();
        // simultaneous push and pop at fill 1
        rsp_ready = 0;
        send(8'd7, 8'd8, 1'b0, 16'd56);
        repeat (ML + 1) @(posedge clk);
        #1 check("fill_one", fill, 1);
        send(8'h80, 8'h02, 1'b1, 16'hFF00);
        repeat (ML) @(posedge clk);
        #1 rsp_ready = 1;
        @(posedge clk);
        #1 rsp_ready = 0;
        check("fill_pushpop_one", fill, 1);
        rsp_ready = 1;
        drain();
        // reset in the middle of WAIT
        send(8'h55, 8'h66, 1'b0, 16'h21DE);
        @(posedge clk);
        #1 check("busy_wait", busy, 1);
        rst = 1;
        void'(exp_q.pop_back());
        #1 check_zero("midreset");
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (10) @(posedge clk);
        #1 check("no_late_valid", rsp_valid, 0);
        check("no_late_jobs", jobs_done, 0);
        send(8'd7, 8'd9, 1'b0, 16'h003F);
        drain();
        check("jobs_fresh", jobs_done, 1);
        // counter wrap over 257 jobs
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 257; i++) begin
            logic [7:0] a, b;
            a = 8'(i * 37 + 1);
            b = 8'(i * 11 + 3);
            send(a, b, i[0], model(a, b, i[0]));
        end
        drain();
        check("jobs_wrap", jobs_done, 1);
        check("fill_end", fill, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
